// File: rtl/cdc_2phase_src_clearable.sv
// Source half of a clearable 2-phase (toggle) handshake CDC. A word is launched by
// toggling async_req_o with the payload held stable until the synchronized ack matches.
module cdc_2phase_src_clearable #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             async_req_o,
  input  logic             async_ack_i,
  output logic [WIDTH-1:0] async_data_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  state_e                 state_r;
  state_e                 state_next_s;
  logic                   req_r;
  logic [WIDTH-1:0]       data_r;
  logic [SYNC_STAGES-1:0] ack_sync_r;
  logic                   ack_sync_s;
  logic                   capture_s;
  logic                   clear_active_s;

  assign ack_sync_s     = ack_sync_r[SYNC_STAGES-1];
  assign clear_active_s = clear_i | (state_r == CLEAR);
  assign async_req_o    = req_r;
  assign async_data_o   = data_r;
  assign busy_o         = (state_r != IDLE);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, capture strobe and upstream ready; clear_i overrides any handshake
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    ready_o      = 1'b0;
    if (clear_i) begin
      state_next_s = CLEAR;
    end else begin
      case (state_r)
        IDLE: begin
          ready_o = 1'b1;
          if (valid_i) begin
            capture_s    = 1'b1;
            state_next_s = BUSY;
          end else begin
            state_next_s = IDLE;
          end
        end
        BUSY: begin
          if (ack_sync_s == req_r) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = BUSY;
          end
        end
        CLEAR:   state_next_s = IDLE;
        default: state_next_s = CLEAR;
      endcase
    end
  end

  // Ack synchronizer; flushed during clear so a stale destination toggle cannot leak through
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_sync_r <= {SYNC_STAGES{1'b0}};
    end else if (clear_active_s) begin
      ack_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], async_ack_i};
    end
  end

  // Request toggle and payload hold registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_r  <= 1'b0;
      data_r <= {WIDTH{1'b0}};
    end else if (clear_active_s) begin
      req_r  <= 1'b0;
      data_r <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      req_r  <= ~req_r;
      data_r <= data_i;
    end else begin
      req_r  <= req_r;
      data_r <= data_r;
    end
  end

  cdc_2phase_src_clearable_chk u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .idle_s     (state_r == IDLE),
    .ack_sync_s (ack_sync_s),
    .req_s      (req_r)
  );

endmodule

// Protocol checker: at rest the synchronized ack must already match the request.
module cdc_2phase_src_clearable_chk (
  input logic clk_i,
  input logic rst_i,
  input logic clear_i,
  input logic idle_s,
  input logic ack_sync_s,
  input logic req_s
);

  idle_ack_match_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (idle_s && !clear_i) |-> (ack_sync_s == req_s));

endmodule

// File: doc/cdc_2phase_src_clearable.md
CDC_2PHASE_SRC_CLEARABLE -- requirements
Module: cdc_2phase_src_clearable

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the payload width in bits (WIDTH >= 1).
REQ-002 SHALL have parameter SYNC_STAGES, default 3, the number of ack synchronizer flops (SYNC_STAGES >= 2); SHALL equal the SYNC_STAGES of the cdc_clear_sync instance driving clear_i.
REQ-003 SHALL have port clk_i, input, 1, the source-domain clock and the only clock of the block.
REQ-004 SHALL have port rst_i, input, 1, the reset: asynchronous and active-high.
REQ-005 SHALL have port clear_i, input, 1, the synchronous clear, driven by the local-side clear_o of cdc_clear_sync.
REQ-006 SHALL have port valid_i, input, 1, the upstream valid.
REQ-007 SHALL have port ready_o, output, 1, the upstream ready.
REQ-008 SHALL have port data_i, input, WIDTH, the upstream payload.
REQ-009 SHALL have port async_req_o, output, 1, the 2-phase request toggle to the destination half.
REQ-010 SHALL have port async_ack_i, input, 1, the 2-phase acknowledge toggle from the destination half, asynchronous to clk_i.
REQ-011 SHALL have port async_data_o, output, WIDTH, the payload held stable toward the destination half.
REQ-012 SHALL have port busy_o, output, 1, high while a transfer is outstanding or a clear is in progress.

Function
REQ-013 SHALL synchronize async_ack_i with a SYNC_STAGES-deep flop chain clocked by clk_i; ack_sync is the last flop.
REQ-014 SHALL implement an FSM with states IDLE, BUSY and CLEAR.
REQ-015 SHALL drive ready_o = 1 only in IDLE with clear_i = 0; otherwise ready_o = 0.
REQ-016 SHALL, in IDLE with valid_i & ready_o, on that edge: capture data_i into async_data_o, toggle req_q (which drives async_req_o), and go to BUSY.
REQ-017 SHALL, in BUSY, hold async_req_o and async_data_o stable, and return to IDLE on the first edge where ack_sync == req_q.
REQ-018 SHALL ensure minimum handshake-to-ready latency: async_ack_i toggling at edge k yields ready_o = 1 after edge k + SYNC_STAGES.
REQ-019 SHALL enter CLEAR from any state on any edge with clear_i = 1; in CLEAR: req_q <= 0, async_data_o <= 0, all ack synchronizer flops <= 0, ready_o = 0.
REQ-020 SHALL give clear_i priority over a simultaneous valid_i & ready_o: no capture, no toggle.
REQ-021 SHALL, in CLEAR, go to IDLE on the first edge with clear_i = 0; ready_o may assert in the following cycle.
REQ-022 SHALL abandon an outstanding transfer on clear mid-BUSY; the abandoned word is not reported and not retried.
REQ-023 SHALL ignore ack_sync in CLEAR; ack_sync != req_q in IDLE is a protocol error and is flagged by assertion (non-synthesis).
REQ-024 SHALL set busy_o = (state != IDLE).
REQ-025 SHALL keep async_req_o and async_data_o registered outputs with no combinational path from any input.

Reset
REQ-026 SHALL, while rst_i = 1, asynchronously force: state = CLEAR, req_q = 0, async_data_o = 0, all sync flops = 0, ready_o = 0, busy_o = 1.
REQ-027 SHALL, after rst_i deasserts, leave CLEAR only via REQ-021, i.e. after clear_i (asserted by cdc_clear_sync on async reset) has been seen and dropped.
REQ-028 SHALL allow rst_i assertion in any state, with the REQ-026 values taking effect without a clock edge.

Verification
REQ-029 SHALL cover single transfer, SYNC_STAGES = 3: data_i = 0xA5A5A5A5, valid at edge 0 -> async_req_o 0->1 and async_data_o = 0xA5A5A5A5 after edge 0; ack toggles at edge 4 -> ready_o = 1 after edge 7.
REQ-030 SHALL cover back-to-back transfers: 4 words with ack returned 2 cycles after each req -> async_req_o toggles exactly 4 times (1,0,1,0) and the words appear in order.
REQ-031 SHALL cover clear mid-BUSY: clear_i high 5 cycles while BUSY with req_q = 1 -> async_req_o = 0, async_data_o = 0, ready_o = 0 throughout; IDLE and ready_o = 1 two cycles after clear_i falls.
REQ-032 SHALL cover simultaneous clear and handshake: valid_i = 1, ready_o = 1, clear_i = 1 on the same edge -> no toggle, state = CLEAR.
REQ-033 SHALL cover async reset mid-transfer: rst_i pulsed between edges while BUSY -> outputs at REQ-026 values immediately, ready_o stays 0 until clear_i is seen and dropped.
REQ-034 SHALL cover stale ack: async_ack_i toggled while in CLEAR -> no state change, and the first transfer after clear completes normally.
